seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

- Time-multiplexed scan controller for a DIGITS-wide seven-segment display; one shared BCD-to-7-segment decoder serves all digits.
- Latches a packed BCD word into a shadow register and commits it only at frame boundaries, so a frame never mixes old and new digits.
- Steps through the digits, presenting each digit's BCD code to the external decoder. It registers the returned segment pattern and drives a one-hot anode enable, with a blanking gap between digits.
- Sits between the value-producing logic and the display pins.

## Interface
- DIGITS, 4: number of display digits (≥2).
- BCD_WIDTH, 4: bits per BCD digit.
- SEG_WIDTH, 7: segment pattern width; active-high, matches the decoder output.
- ON_CYCLES, 4: cycles each digit's anode is lit (≥1).
- GAP_CYCLES, 1: cycles with all anodes off between digits (≥1).

- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low forces display dark.
- load  in  1  one-cycle strobe: capture bcd_in into the shadow register.
- bcd_in  in  DIGITS*BCD_WIDTH  packed digits; digit 0 is bits [BCD_WIDTH-1:0].
- dec_bcd  out  BCD_WIDTH  combinational: active[digit], fed to the external decoder.
- dec_seg  in  SEG_WIDTH  combinational segment pattern returned by the decoder.
- seg_out  out  SEG_WIDTH  registered segment drive.
- an  out  DIGITS  registered one-hot anode enable, active-high.
- pending  out  1  shadow holds a value not yet committed.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- State: FETCH, SHOW, GAP. Registers:
  - digit index: $clog2(DIGITS) bits.
  - cycle counter: wide enough for max(ON_CYCLES, GAP_CYCLES).
  - active word and shadow word: DIGITS*BCD_WIDTH each.
- Reset values:
  - state=FETCH, digit=0, counter=0.
  - active=0, shadow=0, pending=0.
  - an=0, seg_out=0, frame_done=0.
- FETCH, 1 cycle:
  - dec_bcd = active[digit].
  - On exit: seg_out<=dec_seg (subject to blanking), an<=one-hot(digit), counter cleared, go to SHOW.
- SHOW, ON_CYCLES cycles:
  - an and seg_out held.
  - After the last cycle: an<=0, seg_out<=0, go to GAP.
- GAP, GAP_CYCLES cycles:
  - Outputs dark.
  - After the last cycle, if digit<DIGITS-1: digit+1, go to FETCH.
  - Otherwise, frame end: digit<=0, frame_done<=1 for one cycle, go to FETCH. If pending: active<=shadow, pending<=0.
- Load:
  - load=1 writes shadow<=bcd_in and sets pending=1.
  - A repeated load before commit overwrites the shadow (last wins).
  - load on the same cycle as a commit: old shadow commits, new bcd_in goes to shadow, pending stays 1.
- Codes >9 are not filtered; the decoder's output for them is displayed as returned (the team decoder returns 0, i.e. blank).
- Enable low:
  - Next edge: an=0, seg_out=0, state=FETCH, digit=0, counter=0. Held there while en=0.
  - frame_done is not pulsed while disabled.
  - A pending value commits on the first disabled cycle.
  - When en returns high, FETCH of digit 0 occurs that cycle.
- rst mid-frame or with a value pending: full return to reset values; the shadow contents are discarded.

## Timing
- Digit period = 1+ON_CYCLES+GAP_CYCLES cycles. Frame = DIGITS × digit period.
- The anode for digit d rises one cycle after FETCH of d and lasts exactly ON_CYCLES cycles.
- an is never multi-hot. an and seg_out change only on FETCH→SHOW and SHOW→GAP.
- load → pending high next cycle. New digits appear on an at the first FETCH after the next frame_done, with latency ≤ one frame + 2 cycles.
- frame_done is high on the cycle of the first FETCH of digit 0 of the new frame.
- First frame after reset displays all zeros.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - At FETCH of digit d>0, seg_out<=0 if active digits d..DIGITS-1 are all zero.
  - The anode still follows the schedule.
  - Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: every digit shows its decoded pattern; no extra logic.

## Test plan
Bench uses DIGITS=4, ON=4, GAP=1 and a behavioural decoder (0→1111110, 4→0110011, 5→1011011, >9→0).
- Load 16'h1234 after reset -> pending=1 until the first frame_done (cycle 24). The next frame shows an 0001,0010,0100,1000 with seg 0110011,1111001,1101101,0110000, each 4 cycles, separated by 1-cycle all-dark gaps.
- Load 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed after the commit; pending clears on the frame_done cycle.
- Load on the exact commit cycle -> the old shadow is displayed, pending remains 1, and the new value is displayed one frame later.
- Load 16'h0050:
  - With LEADING_ZERO_BLANK_EN, digits 3 and 2 show seg 0 with their anodes still pulsing; digit 1 shows 1011011 and digit 0 shows 1111110.
  - Without the macro, all four digits are decoded.
- en low during SHOW of digit 2 -> an=0 and seg_out=0 next cycle. en high 10 cycles later -> FETCH of digit 0 that cycle, an=0001 on the following cycle.
- rst asserted mid-frame with pending=1 -> next cycle all outputs 0, pending=0, active=0, and scanning restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the value producer, the shared BCD decoder and the display pins
// of seg7_scan_ctrl. The controller takes the slave side.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS    = 4,
    parameter int BCD_WIDTH = 4,
    parameter int SEG_WIDTH = 7
);
    logic                          en;
    logic                          load;
    logic [DIGITS*BCD_WIDTH-1:0]   bcd_in;
    logic [BCD_WIDTH-1:0]          dec_bcd;
    logic [SEG_WIDTH-1:0]          dec_seg;
    logic [SEG_WIDTH-1:0]          seg_out;
    logic [DIGITS-1:0]             an;
    logic                          pending;
    logic                          frame_done;

    modport master (
        output en, load, bcd_in, dec_seg,
        input  dec_bcd, seg_out, an, pending, frame_done
    );

    modport slave (
        input  en, load, bcd_in, dec_seg,
        output dec_bcd, seg_out, an, pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Seven-segment scan controller: FETCH/SHOW/GAP per digit, frame-synchronous value commit.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int BCD_WIDTH  = 4,
    parameter int SEG_WIDTH  = 7,
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int WORD_W  = DIGITS * BCD_WIDTH;
    localparam int DIG_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {FETCH, SHOW, GAP} state_e;

    state_e                state_q, state_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_W-1:0]     active_q, active_d;
    logic [WORD_W-1:0]     shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [SEG_WIDTH-1:0]  seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    logic frame_end;
    logic commit;
    logic blank;

    // NOTE: active and shadow words are reset like any other flop: the first
    // frame must show zeros and a reset has to discard an uncommitted shadow.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            digit_q      <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '0;
            seg_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        if (!bus.en) begin
            state_d = FETCH;
            digit_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                        digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[d]: digits d..DIGITS-1 of the active word are all zero.
    logic [DIGITS-1:0] upper_zero;

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            upper_zero[d] = 1'b1;
            for (int k = d; k < DIGITS; k++) begin
                if (active_q[k*BCD_WIDTH +: BCD_WIDTH] != '0) upper_zero[d] = 1'b0;
            end
        end
    end

    assign blank = (digit_q != '0) && upper_zero[digit_q];
`else
    assign blank = 1'b0;
`endif

    // Commit happens at the frame boundary or on any disabled cycle; a load in
    // the same cycle lands in the shadow and keeps pending set.
    assign frame_end = bus.en && (state_q == GAP) && (cnt_q == GAP_LAST)
                       && (digit_q == LAST_DIGIT);
    assign commit    = pending_q && (frame_end || !bus.en);

    always_comb begin
        an_d         = an_q;
        seg_d        = seg_q;
        frame_done_d = frame_end;
        active_d     = commit ? shadow_q : active_q;
        shadow_d     = bus.load ? bus.bcd_in : shadow_q;
        pending_d    = bus.load || (pending_q && !commit);
        if (!bus.en) begin
            an_d  = '0;
            seg_d = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    an_d  = DIGITS'(1) << digit_q;
                    seg_d = blank ? '0 : bus.dec_seg;
                end
                SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        an_d  = '0;
                        seg_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dec_bcd    = active_q[digit_q*BCD_WIDTH +: BCD_WIDTH];
    assign bus.seg_out    = seg_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIGITS=4, ON=4, GAP=1) with a behavioural decoder.
// Expected frames go into a scoreboard queue at load time and are popped when the DUT shows them.
module tb_seg7_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int ON     = 4;
    localparam int GAP    = 1;
    localparam int PERIOD = 1 + ON + GAP;
    localparam int FRAME  = DIGITS * PERIOD;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b0000000;
`else
    localparam logic [6:0] LZ = 7'b1111110;
`endif

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0][6:0] seg;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    frame_t sb_q[$];
    bit     sb_pending = 1'b0;
    frame_t vecs[6];

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.DIGITS(4), .BCD_WIDTH(4), .SEG_WIDTH(7)) bus ();

    seg7_scan_ctrl #(
        .DIGITS(4), .BCD_WIDTH(4), .SEG_WIDTH(7), .ON_CYCLES(ON), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [6:0] decode(input logic [3:0] b);
        case (b)
            4'd0: decode = 7'b1111110;
            4'd1: decode = 7'b0110000;
            4'd2: decode = 7'b1101101;
            4'd3: decode = 7'b1111001;
            4'd4: decode = 7'b0110011;
            4'd5: decode = 7'b1011011;
            4'd6: decode = 7'b1011111;
            4'd7: decode = 7'b1110000;
            4'd8: decode = 7'b1111111;
            4'd9: decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb bus.dec_seg = decode(bus.dec_bcd);

    function automatic frame_t mk(input logic [15:0] v, input logic [6:0] s0,
                                  input logic [6:0] s1, input logic [6:0] s2,
                                  input logic [6:0] s3);
        frame_t f;
        f.value  = v;
        f.seg[0] = s0;
        f.seg[1] = s1;
        f.seg[2] = s2;
        f.seg[3] = s3;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sb_load(input frame_t f);
        if (sb_pending && sb_q.size() > 0) sb_q[sb_q.size()-1] = f;
        else sb_q.push_back(f);
        sb_pending = 1'b1;
    endtask

    task automatic sb_pop(output frame_t f);
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_pop: got queue size 0 want at least 1");
            f = '0;
        end else begin
            f = sb_q.pop_front();
        end
    endtask

    // Drives a one-cycle load; returns one cycle later with pending checked.
    task automatic load_pulse(input frame_t f, input bit at_commit);
        if (at_commit) sb_pending = 1'b0;
        sb_load(f);
        bus.load   = 1'b1;
        bus.bcd_in = f.value;
        step();
        bus.load = 1'b0;
        check($sformatf("pending_after_load_%h", f.value), bus.pending, 1);
    endtask

    task automatic wait_fd(input int limit, output int n);
        n = 0;
        while (bus.frame_done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check("frame_done_seen", bus.frame_done, 1);
    endtask

    // Samples one full frame starting at its first FETCH of digit 0.
    task automatic check_frame(input frame_t f, input logic fd_exp);
        int d;
        int ph;
        logic lit;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0) step();
            d     = t / PERIOD;
            ph    = t % PERIOD;
            lit   = (ph >= 1) && (ph <= ON);
            an_e  = lit ? 4'(1 << d) : 4'b0000;
            seg_e = lit ? f.seg[d] : 7'b0000000;
            check($sformatf("an_%h_t%0d", f.value, t), bus.an, an_e);
            check($sformatf("seg_%h_t%0d", f.value, t), bus.seg_out, seg_e);
            check($sformatf("fd_%h_t%0d", f.value, t), bus.frame_done,
                  (t == 0) ? fd_exp : 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f;
        int n;

        vecs[0] = mk(16'h1234, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);
        vecs[1] = mk(16'h0050, 7'b1111110, 7'b1011011, LZ,         LZ);
        vecs[2] = mk(16'h9AF0, 7'b1111110, 7'b0000000, 7'b0000000, 7'b1111011);
        vecs[3] = mk(16'h8765, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111);
        vecs[4] = mk(16'h0100, 7'b1111110, 7'b1111110, 7'b0110000, LZ);
        vecs[5] = mk(16'h0000, 7'b1111110, LZ,         LZ,         LZ);

        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state and the all-zero first frame (no frame_done on cycle 0).
        check("rst_an", bus.an, 0);
        check("rst_seg", bus.seg_out, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_dec_bcd", bus.dec_bcd, 0);
        check_frame(mk(16'h0000, 7'b1111110, LZ, LZ, LZ), 1'b0);

        // Table: load on a frame_done cycle, commit lands one frame later.
        for (int i = 0; i < 6; i++) begin
            step();
            load_pulse(vecs[i], 1'b0);
            wait_fd(3 * FRAME, n);
            check($sformatf("commit_latency_%0d", i), n, FRAME - 1);
            check($sformatf("pending_clear_%0d", i), bus.pending, 0);
            sb_pending = 1'b0;
            sb_pop(f);
            check_frame(f, 1'b1);
        end

        // Repeated load before commit: last value wins.
        step();
        load_pulse(mk(16'h1111, 7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000), 1'b0);
        repeat (4) step();
        load_pulse(mk(16'h2222, 7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101), 1'b0);
        wait_fd(3 * FRAME, n);
        check("last_wins_latency", n, 18);
        check("last_wins_pending", bus.pending, 0);
        sb_pending = 1'b0;
        sb_pop(f);
        check_frame(f, 1'b1);

        // Load on the exact commit cycle: old shadow shows, new one a frame later.
        step();
        load_pulse(mk(16'h5678, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011), 1'b0);
        repeat (22) step();
        check("collide_pre_fd", bus.frame_done, 0);
        check("collide_pre_pending", bus.pending, 1);
        load_pulse(mk(16'h4040, 7'b1111110, 7'b0110011, 7'b1111110, 7'b0110011), 1'b1);
        check("collide_fd", bus.frame_done, 1);
        sb_pop(f);
        check_frame(f, 1'b1);
        step();
        check("collide_fd2", bus.frame_done, 1);
        check("collide_pending2", bus.pending, 0);
        sb_pending = 1'b0;
        sb_pop(f);
        check_frame(f, 1'b1);

        // Enable dropped during SHOW of digit 2 with a value pending.
        step();
        repeat (12) step();
        load_pulse(mk(16'h0907, 7'b1110000, 7'b1111110, 7'b1111011, LZ), 1'b0);
        step();
        check("en_show_d2_an", bus.an, 4'b0100);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("dis_an_%0d", i), bus.an, 0);
            check($sformatf("dis_seg_%0d", i), bus.seg_out, 0);
            check($sformatf("dis_fd_%0d", i), bus.frame_done, 0);
            if (i == 0) begin
                check("dis_commit_pending", bus.pending, 0);
                check("dis_commit_dec_bcd", bus.dec_bcd, 4'h7);
            end
        end
        sb_pending = 1'b0;
        bus.en = 1'b1;
        sb_pop(f);
        check_frame(f, 1'b0);

        // Reset mid-frame with a value pending discards the shadow.
        step();
        load_pulse(mk(16'h4321, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011), 1'b0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        sb_pending = 1'b0;
        check("mid_rst_an", bus.an, 0);
        check("mid_rst_seg", bus.seg_out, 0);
        check("mid_rst_pending", bus.pending, 0);
        check("mid_rst_fd", bus.frame_done, 0);
        check("mid_rst_dec_bcd", bus.dec_bcd, 0);
        load_pulse(vecs[0], 1'b0);
        check("restart_an", bus.an, 4'b0001);
        check("restart_seg", bus.seg_out, 7'b1111110);
        for (int c = 1; c < FRAME; c++) begin
            check($sformatf("post_rst_pending_c%0d", c), bus.pending, 1);
            check($sformatf("post_rst_fd_c%0d", c), bus.frame_done, 0);
            check($sformatf("post_rst_dec_bcd_c%0d", c), bus.dec_bcd, 0);
            step();
        end
        check("post_rst_fd24", bus.frame_done, 1);
        check("post_rst_pending24", bus.pending, 0);
        sb_pending = 1'b0;
        sb_pop(f);
        check_frame(f, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
